online_iter_sequencer: RTL

//   Synchronous, parametrised iteration sequencer for digit-serial online operators.

---
 rtl/online_iter_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/online_iter_sequencer.sv
// Iteration sequencer for digit-serial online operators: DELTA warm-up cycles,
// then num_digits digit steps, then a one-cycle done pulse. Stall and abort supported.
//
//   state  | meaning
//   IDLE   | waiting for start
//   WARMUP | online-delay cycles before the first digit
//   ACTIVE | one digit step per non-stalled cycle
//   DONE   | single-cycle completion pulse
module online_iter_sequencer #(
    parameter int WIDTH = 14,
    parameter int DELTA = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] num_digits,
    input  logic             stall,
    input  logic             abort,
    output logic             busy,
    output logic             warmup,
    output logic             digit_valid,
    output logic [WIDTH-1:0] digit_idx,
    output logic             last,
    output logic             done
);

    // Keep the warm-up counter at least one bit wide so DELTA=0 stays legal.
    localparam int WW = (DELTA > 0) ? $clog2(DELTA + 1) : 1;
    localparam logic [WW-1:0] WARM_LAST = (DELTA > 0) ? WW'(DELTA - 1) : '0;

    typedef enum logic [1:0] {IDLE, WARMUP, ACTIVE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WW-1:0]    warm_q, warm_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic             is_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            warm_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            warm_q  <= warm_d;
            idx_q   <= idx_d;
        end
    end

    assign is_last = (state_q == ACTIVE) && (idx_q == n_q - WIDTH'(1));

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        warm_d  = warm_q;
        idx_d   = idx_q;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            n_d     = '0;
            warm_d  = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        n_d    = num_digits;
                        idx_d  = '0;
                        warm_d = '0;
                        if (num_digits == '0)
                            state_d = DONE;
                        else if (DELTA > 0)
                            state_d = WARMUP;
                        else
                            state_d = ACTIVE;
                    end
                end
                WARMUP: begin
                    if (!stall) begin
                        if (warm_q == WARM_LAST) begin
                            state_d = ACTIVE;
                            warm_d  = '0;
                        end else begin
                            warm_d = warm_q + WW'(1);
                        end
                    end
                end
                ACTIVE: begin
                    // On the last digit the index holds rather than stepping to N.
                    if (!stall) begin
                        if (is_last)
                            state_d = DONE;
                        else
                            idx_d = idx_q + WIDTH'(1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign warmup      = (state_q == WARMUP);
    assign digit_valid = (state_q == ACTIVE) && !stall;
    assign digit_idx   = (state_q == ACTIVE) ? idx_q : '0;
    assign last        = is_last;
    assign done        = (state_q == DONE);

endmodule
